// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the single-port data memory.
// Optional grant/conflict counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              err0,
  output logic              err1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_gnt0,
  output logic [15:0]       stat_gnt1,
  output logic [15:0]       stat_conflict
`endif
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e state_q;
  logic   last_q;
  logic   lat_id_q;
  logic   lat_we_q;
  logic   lat_oor_q;

  logic              any_req;
  logic              both_req;
  logic              win_id;
  logic              win_we;
  logic              win_oor;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  always_comb begin
    any_req   = req0 | req1;
    both_req  = req0 & req1;
    // On conflict the requester that was not granted last wins.
    win_id    = both_req ? ~last_q : req1;
    win_we    = win_id ? we1 : we0;
    win_addr  = win_id ? addr1 : addr0;
    win_wdata = win_id ? wdata1 : wdata0;
    win_oor   = (win_addr >= ADDR_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      lat_id_q  <= 1'b0;
      lat_we_q  <= 1'b0;
      lat_oor_q <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef DMEM_ARB_STATS_EN
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
`endif
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q   <= StAccess;
            last_q    <= win_id;
            lat_id_q  <= win_id;
            lat_we_q  <= win_we;
            lat_oor_q <= win_oor;
            gnt0      <= ~win_id;
            gnt1      <= win_id;
            // mem_addr/mem_wdata double as the latched request attributes.
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            mem_read  <= ~win_we & ~win_oor;
            mem_write <= win_we & ~win_oor;
`ifdef DMEM_ARB_STATS_EN
            if (!win_id && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
            if (win_id && stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 16'd1;
            if (both_req && stat_conflict != 16'hFFFF) begin
              stat_conflict <= stat_conflict + 16'd1;
            end
`endif
          end
        end
        StAccess: begin
          state_q <= StIdle;
          if (lat_oor_q) begin
            err0 <= ~lat_id_q;
            err1 <= lat_id_q;
          end else if (!lat_we_q) begin
            if (lat_id_q) begin
              rvalid1 <= 1'b1;
              rdata1  <= mem_rdata;
            end else begin
              rvalid0 <= 1'b1;
              rdata0  <= mem_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a simple word memory model.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 200;

  logic              clk;
  logic              rst_n;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  int checks;
  int errors;

  logic [DATA_W-1:0] mem [DEPTH];

  dmem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .err0     (err0),
    .err1     (err1),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_gnt0    (stat_gnt0),
    .stat_gnt1    (stat_gnt1),
    .stat_conflict(stat_conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous read, write committed on the rising edge.
  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[7:0]] : '0;
  always @(posedge clk) begin
    if (mem_write && mem_addr < DEPTH) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request from an IDLE negedge; returns at the completion-cycle negedge.
  task automatic txn(input string tag, input bit id, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit exp_mw, input bit exp_mr,
                     input bit exp_rv, input bit exp_err, input logic [31:0] exp_rd);
    logic [1:0] onehot;
    onehot = id ? 2'b10 : 2'b01;
    if (id) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
    @(negedge clk);
    check_eq({tag, "_gnt"}, {30'd0, gnt1, gnt0}, {30'd0, onehot});
    check_eq({tag, "_mem_write"}, {31'd0, mem_write}, {31'd0, exp_mw});
    check_eq({tag, "_mem_read"}, {31'd0, mem_read}, {31'd0, exp_mr});
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    check_eq({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, exp_rv ? {30'd0, onehot} : 32'd0);
    check_eq({tag, "_err"}, {30'd0, err1, err0}, exp_err ? {30'd0, onehot} : 32'd0);
    check_eq({tag, "_idle_rw"}, {30'd0, mem_read, mem_write}, 32'd0);
    if (exp_rv) check_eq({tag, "_rdata"}, id ? rdata1 : rdata0, exp_rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] gnt_pat [8];

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h0;
    mem[10]  = 32'd5;
    mem[199] = 32'hDEAD_BEEF;
    gnt_pat[0] = 2'b01; gnt_pat[1] = 2'b00; gnt_pat[2] = 2'b10; gnt_pat[3] = 2'b00;
    gnt_pat[4] = 2'b01; gnt_pat[5] = 2'b00; gnt_pat[6] = 2'b10; gnt_pat[7] = 2'b00;

    // Reset with both requesters asserting.
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_pulses", {26'd0, gnt0, gnt1, rvalid0, rvalid1, err0, err1}, 32'd0);
    check_eq("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_rdata", rdata0 | rdata1, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("rr_gnt_%0d", i), {30'd0, gnt1, gnt0}, {30'd0, gnt_pat[i]});
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);

    txn("wr1_a8", 1'b1, 1'b1, 32'd8, 32'hF0F0_F0F0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    txn("rd0_a8", 1'b0, 1'b0, 32'd8, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hF0F0_F0F0);
    txn("rd0_a10", 1'b0, 1'b0, 32'd10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd5);
    txn("oor_wr200", 1'b0, 1'b1, 32'd200, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("oor_rdata_hold", rdata0, 32'd5);
    txn("rd0_a199", 1'b0, 1'b0, 32'd199, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    txn("oor_rd_big", 1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    txn("rd1_a199", 1'b1, 1'b0, 32'd199, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    check_eq("rdata0_hold", rdata0, 32'hDEAD_BEEF);

    // Reset during the ACCESS of a requester-0 read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd10;
    @(negedge clk);
    check_eq("abort_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    check_eq("abort_cleared", {28'd0, gnt0, mem_read, rvalid0, err0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("abort_quiet_%0d", i),
               {26'd0, gnt0, gnt1, rvalid0, rvalid1, err0, err1}, 32'd0);
    end
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'd10; addr1 = 32'd10;
    @(negedge clk);
    check_eq("post_rst_conflict", {30'd0, gnt1, gnt0}, 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    check_eq("post_rst_rdata0", rdata0, 32'd5);
    @(negedge clk);
    check_eq("post_rst_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
    req1 = 1'b0;
    @(negedge clk);
    check_eq("post_rst_rvalid1", {31'd0, rvalid1}, 32'd1);
    check_eq("post_rst_rdata1", rdata1, 32'd5);
    @(negedge clk);

`ifdef DMEM_ARB_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("stat_rst", {stat_gnt0 | stat_gnt1 | stat_conflict}, 32'd0);
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'd1; addr1 = 32'd2;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    txn("stat_solo_a", 1'b1, 1'b0, 32'd3, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    txn("stat_solo_b", 1'b1, 1'b0, 32'd4, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("stat_gnt0", {16'd0, stat_gnt0}, 32'd3);
    check_eq("stat_gnt1", {16'd0, stat_gnt1}, 32'd5);
    check_eq("stat_conflict", {16'd0, stat_conflict}, 32'd6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port, word-addressed data memory (MemRead/MemWrite, ALUOut address, reg2data write data, memout read data).
- Requester 0 is the CPU load/store path; requester 1 is the DMA/test loader port.
- Each accepted request is latched and driven onto the memory for exactly one ACCESS cycle. Read data is registered and returned with a one-cycle valid pulse.
- Sits between the requesters and the Data_Memory instance, and owns all of that instance's control inputs.

Parameters:
- ADDR_W, 32: address width of requester and memory address ports.
- DATA_W, 32: data width.
- DEPTH, 200: number of implemented memory words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1 each  request; held high with attributes stable until the matching gnt is seen.
- we0, we1  in  1 each  1 = write, 0 = read.
- addr0, addr1  in  ADDR_W each  word address.
- wdata0, wdata1  in  DATA_W each  write data.
- gnt0, gnt1  out  1 each  one-cycle pulse: request accepted, memory being accessed this cycle.
- rdata0, rdata1  out  DATA_W each  read data; valid when the matching rvalid is high.
- rvalid0, rvalid1  out  1 each  one-cycle pulse when a read completes.
- err0, err1  out  1 each  one-cycle pulse, same cycle as rvalid would be, for an out-of-range access.
- mem_read, mem_write  out  1 each  drive MemRead/MemWrite.
- mem_addr  out  ADDR_W  drives ALUOut.
- mem_wdata  out  DATA_W  drives reg2data.
- mem_rdata  in  DATA_W  from memout.

Behaviour:
- Reset (async on rst_n low):
  - State = IDLE; last-granted pointer = 1, so requester 0 wins the first conflict.
  - All gnt/rvalid/err/mem_read/mem_write = 0.
  - rdata0/rdata1/mem_addr/mem_wdata = 0; latched request cleared.
- States: IDLE, ACCESS.
- IDLE:
  - If any req is high, pick a winner, latch its we/addr/wdata/id, and go to ACCESS; otherwise stay in IDLE.
  - Only one requester: it wins. Both: the one not equal to the last-granted pointer wins, and the pointer updates to the winner.
- ACCESS (exactly one cycle, then IDLE):
  - gnt of the winner = 1.
  - mem_addr/mem_wdata = latched values.
  - Read: mem_read = 1. Write: mem_write = 1, and the memory commits at the rising edge ending ACCESS.
  - Out of range (addr >= DEPTH): mem_read = mem_write = 0, so no write occurs.
- Completion (the IDLE cycle following ACCESS):
  - In-range read: rdata of the winner = mem_rdata sampled at the end of ACCESS; rvalid of the winner = 1 for one cycle.
  - Write: no rvalid.
  - Out of range: err of the winner = 1; rdata unchanged; no rvalid.
  - rdata holds its value until the next read for that requester.
- Latency and throughput:
  - req seen in cycle N → gnt in N+1 → rvalid/err in N+2.
  - Maximum throughput is one access per 2 cycles. Back-to-back requests: a new arbitration happens in the same IDLE cycle that carries the previous rvalid.
- Outside ACCESS: mem_read and mem_write are 0. mem_addr and mem_wdata are don't-care but held at their last values.
- A requester dropping req while in ACCESS has no effect; the access completes.
- Reset mid-ACCESS: the access is aborted. Whether the in-flight write happens depends on edge ordering; no completion pulse is ever issued.
- The non-winning requester keeps req high and is served on the next arbitration. Under continuous conflict the grant strictly alternates, so neither requester starves.
- The address comparison is unsigned on the full ADDR_W.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_gnt0, stat_gnt1 (16 bits each): saturating counts of grants.
  - Adds output stat_conflict (16 bits): saturating count of IDLE cycles with both req high and an arbitration taken.
  - All three reset to 0.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with req0 = req1 = 1 held → all outputs 0 while rst_n = 0. After release: gnt0 in the first ACCESS, gnt1 in the next ACCESS; pattern 0,1,0,1 over 8 cycles.
- Requester 1 write, addr1 = 8, wdata1 = 0xF0F0F0F0; then requester 0 read, addr0 = 8 → rvalid0 two cycles after req0 is seen, rdata0 = 0xF0F0F0F0, mem_write high only in the write's ACCESS cycle.
- Single req0 read of addr 10 (preloaded 5) → gnt0 at N+1, rvalid0 at N+2, rdata0 = 5; rvalid1/gnt1 stay 0.
- req0 write to addr 200 with wdata 0x1234 → err0 pulses at N+2, mem_write never asserted, rvalid0 = 0; a read of addr 199 still returns its prior value.
- Assert rst_n = 0 during the ACCESS of a read → no rvalid or err afterward, state IDLE, pointer reset so requester 0 wins the next conflict.
- With DMEM_ARB_STATS_EN: 6 conflict arbitrations plus 2 solo req1 → stat_gnt0 = 3, stat_gnt1 = 5, stat_conflict = 6.
